// File: rtl/regfile_scoreboard.sv
// Register file with a per-entry pending-write scoreboard.
// A zeroing sweep runs after every reset, and reads can bypass the writeback port.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic            i_issue,
  input  logic [AW-1:0]   i_issue_addr,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1,
  output logic [XLEN-1:0] o_rs2,
  output logic            o_rs1_busy,
  output logic            o_rs2_busy,
  output logic [AW:0]     o_busy_cnt,
  output logic            o_ready
);

  localparam bit            ZR       = (ZERO_REG != 0);
  localparam bit            BP       = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW:0]   CNT_ONE  = 1;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_idx_q;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy_q;
  logic [AW:0]       busy_cnt_q;

  logic active, we_act, wr_ok, iss_ok, inc, dec, hit1, hit2;

  // Reset is combinationally folded in so outputs go quiet the moment i_rst rises.
  assign active = (state_q == S_READY) && !i_rst;
  assign we_act = active && i_we;
  assign wr_ok  = we_act && !(ZR && i_rd_addr == '0);
  assign iss_ok = active && i_issue && !(ZR && i_issue_addr == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (clr_idx_q == LAST_IDX) state_d = S_READY;
      S_READY: state_d = S_READY;
      default: state_d = S_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_idx_q <= clr_idx_q + AW'(1);
    end
  end

  // NOTE: the array has no reset; the clear sweep zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!i_rst && state_q == S_CLEAR) regs[clr_idx_q] <= '0;
    else if (wr_ok)                   regs[i_rd_addr] <= i_rd_data;
  end

  // Issue is written after writeback so that a same-address set overrides the clear.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      busy_q <= '0;
    end else if (state_q == S_CLEAR) begin
      busy_q[clr_idx_q] <= 1'b0;
    end else begin
      if (we_act) busy_q[i_rd_addr]    <= 1'b0;
      if (iss_ok) busy_q[i_issue_addr] <= 1'b1;
    end
  end

  // Incremental popcount; a clear masked by a same-address set is not a clear.
  assign inc = iss_ok && !busy_q[i_issue_addr];
  assign dec = we_act && busy_q[i_rd_addr] && !(iss_ok && i_issue_addr == i_rd_addr);

  always_ff @(posedge clk) begin
    if (i_rst)              busy_cnt_q <= '0;
    else if (inc && !dec)   busy_cnt_q <= busy_cnt_q + CNT_ONE;
    else if (dec && !inc)   busy_cnt_q <= busy_cnt_q - CNT_ONE;
  end

  assign hit1 = BP && we_act && (i_rd_addr == i_rs1_addr) && !(ZR && i_rs1_addr == '0);
  assign hit2 = BP && we_act && (i_rd_addr == i_rs2_addr) && !(ZR && i_rs2_addr == '0);

  always_comb begin
    o_rs1 = '0;
    o_rs2 = '0;
    if (active && !(ZR && i_rs1_addr == '0)) o_rs1 = hit1 ? i_rd_data : regs[i_rs1_addr];
    if (active && !(ZR && i_rs2_addr == '0)) o_rs2 = hit2 ? i_rd_data : regs[i_rs2_addr];
  end

  assign o_rs1_busy = active && busy_q[i_rs1_addr] && !hit1;
  assign o_rs2_busy = active && busy_q[i_rs2_addr] && !hit2;
  assign o_busy_cnt = busy_cnt_q;
  assign o_ready    = active;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance plus a BYPASS=0 instance sharing stimulus.
// Expected data and busy counts come from a reference model queued as stimulus is driven.
module tb_regfile_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            i_rst, i_we, i_issue;
  logic [AW-1:0]   i_rd_addr, i_issue_addr, i_rs1_addr, i_rs2_addr;
  logic [XLEN-1:0] i_rd_data;
  logic [XLEN-1:0] rs1, rs2, nb_rs1, nb_rs2;
  logic            rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy, ready, nb_ready;
  logic [AW:0]     busy_cnt, nb_busy_cnt;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .i_rst(i_rst), .i_we(i_we), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_issue(i_issue), .i_issue_addr(i_issue_addr), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1(rs1), .o_rs2(rs2), .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_busy_cnt(busy_cnt), .o_ready(ready));

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .i_rst(i_rst), .i_we(i_we), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_issue(i_issue), .i_issue_addr(i_issue_addr), .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1(nb_rs1), .o_rs2(nb_rs2), .o_rs1_busy(nb_rs1_busy), .o_rs2_busy(nb_rs2_busy),
    .o_busy_cnt(nb_busy_cnt), .o_ready(nb_ready));

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [XLEN-1:0] regs_m [NREG];
  logic [NREG-1:0] busy_m;
  wr_t             wr_q [$];
  int              cnt_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_we = 1'b0; i_issue = 1'b0; i_rd_addr = '0; i_rd_data = '0;
    i_issue_addr = '0; i_rs1_addr = '0; i_rs2_addr = '0;
  endtask

  task automatic test_reset();
    int c;
    i_rst = 1'b1;
    idle();
    tick();
    tick();
    i_rs1_addr = 5'd3;
    #2;
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0b expected 0", ready); end
    n_checks++;
    if (rs1 !== '0) begin n_fail++; $display("FAIL reset_rs1: got %0h expected 0", rs1); end
    i_rst = 1'b0;
    c = 0;
    while (!ready && c < 100) begin tick(); c++; end
    n_checks++;
    if (c !== NREG) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected %0d", c, NREG); end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
    for (int i = 0; i < NREG; i++) begin
      i_rs1_addr = AW'(i);
      i_rs2_addr = AW'(NREG - 1 - i);
      #1;
      n_checks++;
      if (rs1 !== '0 || rs2 !== '0) begin
        n_fail++; $display("FAIL reset_read_zero[%0d]: got %0h/%0h expected 0/0", i, rs1, rs2);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    i_we = 1'b1; i_rd_addr = 5'd5; i_rd_data = 32'hDEADBEEF; i_rs1_addr = 5'd5;
    #2;
    n_checks++;
    if (rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %0h expected deadbeef", rs1); end
    n_checks++;
    if (nb_rs1 !== '0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %0h expected 0", nb_rs1); end
    tick();
    i_we = 1'b0;
    #2;
    n_checks++;
    if (rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_next_cycle: got %0h expected deadbeef", rs1); end
    n_checks++;
    if (nb_rs1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nobypass_next_cycle: got %0h expected deadbeef", nb_rs1); end
  endtask

  task automatic test_zero_reg();
    idle();
    i_we = 1'b1; i_rd_addr = '0; i_rd_data = 32'h1234;
    i_issue = 1'b1; i_issue_addr = '0; i_rs1_addr = '0;
    #2;
    n_checks++;
    if (rs1 !== '0) begin n_fail++; $display("FAIL x0_bypass: got %0h expected 0", rs1); end
    tick();
    idle();
    #2;
    n_checks++;
    if (rs1 !== '0) begin n_fail++; $display("FAIL x0_read: got %0h expected 0", rs1); end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL x0_busy_cnt: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_busy();
    idle();
    i_issue = 1'b1; i_issue_addr = 5'd7;
    tick();
    i_issue = 1'b0; i_rs2_addr = 5'd7;
    #2;
    n_checks++;
    if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_issue: got %0b expected 1", rs2_busy); end
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL busy_cnt_issue: got %0d expected 1", busy_cnt); end
    i_we = 1'b1; i_rd_addr = 5'd7; i_rd_data = 32'h55;
    #1;
    n_checks++;
    if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL busy_wb_bypass: got %0b expected 0", rs2_busy); end
    n_checks++;
    if (rs2 !== 32'h55) begin n_fail++; $display("FAIL busy_wb_data: got %0h expected 55", rs2); end
    tick();
    i_we = 1'b0;
    #2;
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL busy_cnt_wb: got %0d expected 0", busy_cnt); end
    n_checks++;
    if (rs2_busy !== 1'b0 || rs2 !== 32'h55) begin
      n_fail++; $display("FAIL busy_after_wb: got %0b/%0h expected 0/55", rs2_busy, rs2);
    end
  endtask

  task automatic test_issue_write_same();
    idle();
    i_issue = 1'b1; i_issue_addr = 5'd3; i_we = 1'b1; i_rd_addr = 5'd3; i_rd_data = 32'h33;
    tick();
    idle();
    i_rs1_addr = 5'd3;
    #2;
    n_checks++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL same_new_cnt: got %0d expected 1", busy_cnt); end
    n_checks++;
    if (rs1_busy !== 1'b1 || rs1 !== 32'h33) begin
      n_fail++; $display("FAIL same_new_state: got %0b/%0h expected 1/33", rs1_busy, rs1);
    end
    i_issue = 1'b1; i_issue_addr = 5'd3; i_we = 1'b1; i_rd_addr = 5'd3; i_rd_data = 32'h44;
    tick();
    idle();
    i_rs1_addr = 5'd3;
    #2;
    n_checks++;
    if (busy_cnt !== 6'd1 || rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL same_busy: got cnt %0d busy %0b expected 1/1", busy_cnt, rs1_busy);
    end
    i_we = 1'b1; i_rd_addr = 5'd3; i_rd_data = 32'h44;
    tick();
    idle();
    #2;
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL same_release: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_mid_reset();
    int c;
    idle();
    i_we = 1'b1; i_rd_addr = 5'd9; i_rd_data = 32'hA5A5A5A5;
    tick();
    idle();
    i_rs1_addr = 5'd9;
    #1;
    n_checks++;
    if (rs1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL pre_reset_x9: got %0h expected a5a5a5a5", rs1); end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (rs1 !== '0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got %0h/%0b expected 0/0", rs1, ready);
    end
    tick();
    i_rst = 1'b0;
    repeat (10) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_we = 1'b1; i_rd_addr = 5'd2; i_rd_data = 32'hFFFF;
    i_issue = 1'b1; i_issue_addr = 5'd4; i_rs1_addr = 5'd2;
    c = 0;
    while (!ready && c < 100) begin
      #1;
      n_checks++;
      if (rs1 !== '0 || rs1_busy !== 1'b0) begin
        n_fail++; $display("FAIL clear_outputs[%0d]: got %0h/%0b expected 0/0", c, rs1, rs1_busy);
      end
      tick();
      c++;
    end
    idle();
    n_checks++;
    if (c !== NREG) begin n_fail++; $display("FAIL restart_clear_len: got %0d expected %0d", c, NREG); end
    i_rs1_addr = 5'd9; i_rs2_addr = 5'd2;
    #1;
    n_checks++;
    if (rs1 !== '0 || rs2 !== '0) begin
      n_fail++; $display("FAIL restart_reads: got %0h/%0h expected 0/0", rs1, rs2);
    end
    n_checks++;
    if (busy_cnt !== '0) begin n_fail++; $display("FAIL restart_busy_cnt: got %0d expected 0", busy_cnt); end
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    busy_m = '0;
  endtask

  task automatic test_back_to_back();
    wr_t w;
    idle();
    for (int i = 1; i <= 12; i++) begin
      i_we = 1'b1; i_rd_addr = AW'(i); i_rd_data = $urandom;
      w.addr = i_rd_addr; w.data = i_rd_data;
      wr_q.push_back(w);
      regs_m[i] = i_rd_data;
      tick();
    end
    idle();
    while (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      i_rs1_addr = w.addr; i_rs2_addr = w.addr;
      #1;
      n_checks++;
      if (rs1 !== w.data || nb_rs2 !== w.data) begin
        n_fail++; $display("FAIL b2b_read x%0d: got %0h/%0h expected %0h", w.addr, rs1, nb_rs2, w.data);
      end
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e_rs1, e_nb_rs2;
    logic            e_busy1, e_nb_busy2;
    int              e_cnt;
    idle();
    for (int n = 0; n < 80; n++) begin
      i_we         = 1'($urandom_range(0, 1));
      i_rd_addr    = AW'($urandom_range(0, 7));
      i_rd_data    = $urandom;
      i_issue      = 1'($urandom_range(0, 1));
      i_issue_addr = AW'($urandom_range(0, 7));
      i_rs1_addr   = AW'($urandom_range(0, 7));
      i_rs2_addr   = AW'($urandom_range(0, 7));
      if (i_rs1_addr == '0) e_rs1 = '0;
      else if (i_we && i_rd_addr == i_rs1_addr) e_rs1 = i_rd_data;
      else e_rs1 = regs_m[i_rs1_addr];
      e_busy1    = busy_m[i_rs1_addr] && !(i_we && i_rd_addr == i_rs1_addr && i_rs1_addr != '0);
      e_nb_rs2   = (i_rs2_addr == '0) ? '0 : regs_m[i_rs2_addr];
      e_nb_busy2 = busy_m[i_rs2_addr];
      #2;
      n_checks++;
      if (rs1 !== e_rs1 || rs1_busy !== e_busy1) begin
        n_fail++; $display("FAIL rand_rs1[%0d]: got %0h/%0b expected %0h/%0b", n, rs1, rs1_busy, e_rs1, e_busy1);
      end
      n_checks++;
      if (nb_rs2 !== e_nb_rs2 || nb_rs2_busy !== e_nb_busy2) begin
        n_fail++; $display("FAIL rand_nb_rs2[%0d]: got %0h/%0b expected %0h/%0b", n, nb_rs2, nb_rs2_busy, e_nb_rs2, e_nb_busy2);
      end
      if (i_we && i_rd_addr != '0) regs_m[i_rd_addr] = i_rd_data;
      if (i_we) busy_m[i_rd_addr] = 1'b0;
      if (i_issue && i_issue_addr != '0) busy_m[i_issue_addr] = 1'b1;
      cnt_q.push_back($countones(busy_m));
      tick();
      e_cnt = cnt_q.pop_front();
      n_checks++;
      if (int'(busy_cnt) !== e_cnt) begin
        n_fail++; $display("FAIL rand_busy_cnt[%0d]: got %0d expected %0d", n, busy_cnt, e_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_busy();
    test_issue_write_same();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
